fbwriter_clip: RTL and testbench

Parametrised successor to the single-pixel framebuffer writer. It pops pixel records from the rasteriser's pixel FIFO and computes each framebuffer address from a programmable base, stride and pixel format. Pixels outside the clip window are discarded, and each surviving pixel is issued as a single-beat PLB master write with byte enables. It sits between the gl_core_internal pixel FIFO read port and the PLB master IPIF. It adds 16-bpp packing, clipping and statistics counters.

---
 rtl/fbwriter_clip.sv | 135 +++++++++++++
 tb/tb_fbwriter_clip.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fbwriter_clip.sv
// Framebuffer writer: pops {x, y, color} pixel records, clips them against the
// window and issues each surviving pixel as a single-beat PLB master write.
module fbwriter_clip #(
    parameter int COORD_W = 32,
    parameter int COLOR_W = 32,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 32
) (
    input  logic                           PLB_clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [ADDR_W-1:0]              fb_base,
    input  logic [COORD_W-1:0]             fb_stride,
    input  logic [COORD_W-1:0]             fb_width,
    input  logic [COORD_W-1:0]             fb_height,
    input  logic                           pix16,
    input  logic [2*COORD_W+COLOR_W-1:0]   fifo_data,
    input  logic                           fifo_empty,
    output logic                           fifo_rd_en,
    output logic                           IP2Bus_MstWr_Req,
    output logic [ADDR_W-1:0]              IP2Bus_Mst_Addr,
    output logic [3:0]                     IP2Bus_Mst_BE,
    output logic [31:0]                    IP2Bus_MstWr_d,
    input  logic                           Bus2IP_Mst_CmdAck,
    input  logic                           Bus2IP_Mst_Cmplt,
    output logic [3:0]                     state,
    output logic                           busy,
    output logic [CNT_W-1:0]               pix_written,
    output logic [CNT_W-1:0]               pix_dropped
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_POP   = 4'd1,
        S_LATCH = 4'd2,
        S_CALC  = 4'd3,
        S_REQ   = 4'd4,
        S_WAIT  = 4'd5
    } state_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0] rec_x, rec_y;
    logic [COLOR_W-1:0] rec_color;
    logic               clip_out;

    logic [COORD_W-1:0] x_q, y_q;
    logic [COLOR_W-1:0] color_q;

    logic [ADDR_W-1:0]  offset, addr_d;
    logic [3:0]         be_d;
    logic [31:0]        data_d;
    logic               rd_en_d, req_d, busy_d;
    logic               written_inc, dropped_inc;

    assign rec_x     = fifo_data[2*COORD_W+COLOR_W-1 -: COORD_W];
    assign rec_y     = fifo_data[COORD_W+COLOR_W-1 -: COORD_W];
    assign rec_color = fifo_data[COLOR_W-1:0];
    assign clip_out  = (rec_x >= fb_width) || (rec_y >= fb_height);

    assign state = state_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge PLB_clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (enable && !fifo_empty) state_d = S_POP;
            S_POP:   state_d = S_LATCH;
            S_LATCH: state_d = clip_out ? S_IDLE : S_CALC;
            S_CALC:  state_d = S_REQ;
            S_REQ:   if (Bus2IP_Mst_CmdAck) state_d = Bus2IP_Mst_Cmplt ? S_IDLE : S_WAIT;
            S_WAIT:  if (Bus2IP_Mst_Cmplt) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they can be registered
    // and still line up with the state they belong to.
    always_comb begin
        rd_en_d     = (state_d == S_POP);
        req_d       = (state_d == S_REQ);
        busy_d      = (state_d != S_IDLE);
        written_inc = ((state_q == S_REQ) && Bus2IP_Mst_CmdAck && Bus2IP_Mst_Cmplt) ||
                      ((state_q == S_WAIT) && Bus2IP_Mst_Cmplt);
        dropped_inc = (state_q == S_LATCH) && clip_out;

        offset = ADDR_W'(y_q) * ADDR_W'(fb_stride) + ADDR_W'(x_q);
        addr_d = fb_base + (pix16 ? (offset << 1) : (offset << 2));
        be_d   = pix16 ? (addr_d[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        data_d = pix16 ? {color_q[15:0], color_q[15:0]} : 32'(color_q);
    end

    // Pixel holding registers are only read after LATCH loads them, so they
    // carry no reset.
    always_ff @(posedge PLB_clk) begin
        if (state_q == S_LATCH) begin
            x_q     <= rec_x;
            y_q     <= rec_y;
            color_q <= rec_color;
        end
    end

    always_ff @(posedge PLB_clk) begin
        if (reset) begin
            fifo_rd_en       <= 1'b0;
            IP2Bus_MstWr_Req <= 1'b0;
            IP2Bus_Mst_Addr  <= '0;
            IP2Bus_Mst_BE    <= 4'b0000;
            IP2Bus_MstWr_d   <= 32'h0;
            busy             <= 1'b0;
            pix_written      <= '0;
            pix_dropped      <= '0;
        end else begin
            fifo_rd_en       <= rd_en_d;
            IP2Bus_MstWr_Req <= req_d;
            busy             <= busy_d;
            if (state_q == S_CALC) begin
                IP2Bus_Mst_Addr <= addr_d;
                IP2Bus_Mst_BE   <= be_d;
                IP2Bus_MstWr_d  <= data_d;
            end
            if (written_inc) pix_written <= pix_written + 1'b1;
            if (dropped_inc) pix_dropped <= pix_dropped + 1'b1;
        end
    end

endmodule

// File: tb/tb_fbwriter_clip.sv
// Directed bench for fbwriter_clip: addressing, packing, clipping, handshake,
// reset and counter wrap, with hand-computed expectations.
module tb_fbwriter_clip;

    localparam int COORD_W = 32;
    localparam int COLOR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 4;

    logic                         PLB_clk = 1'b0;
    logic                         reset;
    logic                         enable;
    logic [ADDR_W-1:0]            fb_base;
    logic [COORD_W-1:0]           fb_stride, fb_width, fb_height;
    logic                         pix16;
    logic [2*COORD_W+COLOR_W-1:0] fifo_data;
    logic                         fifo_empty;
    logic                         fifo_rd_en;
    logic                         IP2Bus_MstWr_Req;
    logic [ADDR_W-1:0]            IP2Bus_Mst_Addr;
    logic [3:0]                   IP2Bus_Mst_BE;
    logic [31:0]                  IP2Bus_MstWr_d;
    logic                         Bus2IP_Mst_CmdAck;
    logic                         Bus2IP_Mst_Cmplt;
    logic [3:0]                   state;
    logic                         busy;
    logic [CNT_W-1:0]             pix_written, pix_dropped;

    int checks = 0;
    int errors = 0;

    fbwriter_clip #(
        .COORD_W(COORD_W), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .PLB_clk(PLB_clk), .reset(reset), .enable(enable),
        .fb_base(fb_base), .fb_stride(fb_stride), .fb_width(fb_width),
        .fb_height(fb_height), .pix16(pix16), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .IP2Bus_MstWr_Req(IP2Bus_MstWr_Req), .IP2Bus_Mst_Addr(IP2Bus_Mst_Addr),
        .IP2Bus_Mst_BE(IP2Bus_Mst_BE), .IP2Bus_MstWr_d(IP2Bus_MstWr_d),
        .Bus2IP_Mst_CmdAck(Bus2IP_Mst_CmdAck), .Bus2IP_Mst_Cmplt(Bus2IP_Mst_Cmplt),
        .state(state), .busy(busy), .pix_written(pix_written), .pix_dropped(pix_dropped)
    );

    always #5 PLB_clk = ~PLB_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge PLB_clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Pushes one record and services the bus handshake; reports what it saw.
    task automatic drive_pixel(input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] c, input int ack_dly, input int cmplt_dly,
                               output int lat, output logic [31:0] addr,
                               output logic [3:0] be, output logic [31:0] data,
                               output int hold, output logic [3:0] st_ack, output bit to);
        to = 0; lat = 0; hold = 0; st_ack = 4'hF;
        addr = '0; be = '0; data = '0;
        fifo_data  = {x, y, c};
        fifo_empty = 1'b0;
        do begin
            tick();
            lat++;
            if (fifo_rd_en) fifo_empty = 1'b1;
        end while (!IP2Bus_MstWr_Req && lat < 20);
        if (!IP2Bus_MstWr_Req) begin
            to = 1;
            fifo_empty = 1'b1;
            return;
        end
        addr = IP2Bus_Mst_Addr;
        be   = IP2Bus_Mst_BE;
        data = IP2Bus_MstWr_d;
        hold = 1;
        for (int i = 0; i < ack_dly; i++) begin
            Bus2IP_Mst_Cmplt = (i == 0);
            tick();
            Bus2IP_Mst_Cmplt = 1'b0;
            if (IP2Bus_MstWr_Req && IP2Bus_Mst_Addr == addr &&
                IP2Bus_Mst_BE == be && IP2Bus_MstWr_d == data) hold++;
        end
        Bus2IP_Mst_CmdAck = 1'b1;
        Bus2IP_Mst_Cmplt  = (cmplt_dly == 0);
        tick();
        Bus2IP_Mst_CmdAck = 1'b0;
        Bus2IP_Mst_Cmplt  = 1'b0;
        st_ack = state;
        if (cmplt_dly > 0) begin
            for (int i = 1; i < cmplt_dly; i++) tick();
            Bus2IP_Mst_Cmplt = 1'b1;
            tick();
            Bus2IP_Mst_Cmplt = 1'b0;
        end
    endtask

    task automatic drive_drop(input logic [31:0] x, input logic [31:0] y,
                              output int cyc, output bit saw_req);
        cyc = 0; saw_req = 0;
        fifo_data  = {x, y, 32'hDEAD_BEEF};
        fifo_empty = 1'b0;
        do begin
            tick();
            cyc++;
            if (fifo_rd_en) fifo_empty = 1'b1;
            if (IP2Bus_MstWr_Req) saw_req = 1;
        end while (state != 4'd0 && cyc < 20);
        fifo_empty = 1'b1;
    endtask

    task automatic test_reset;
        int bad;
        do_reset();
        checks++;
        if (state !== 4'd0 || busy !== 1'b0 || pix_written !== '0 || pix_dropped !== '0) begin
            errors++;
            $display("FAIL reset_state: state=%0d busy=%b wr=%0d dr=%0d required 0/0/0/0",
                     state, busy, pix_written, pix_dropped);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ({fifo_rd_en, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
                 IP2Bus_MstWr_d, state, busy, pix_written, pix_dropped} !== '0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_outputs: %0d cycles with nonzero outputs, required 0", bad);
        end
    endtask

    task automatic test_32bpp;
        int lat, hold; logic [31:0] a, d; logic [3:0] be, st; bit to;
        pix16 = 1'b0;
        drive_pixel(32'd3, 32'd2, 32'hAABBCCDD, 0, 0, lat, a, be, d, hold, st, to);
        checks++;
        if (to !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL w32_latency: got %0d (timeout %0d) required 4", lat, to);
        end
        checks++;
        if (a !== 32'h1000_140C || be !== 4'b1111 || d !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL w32_beat: addr=%h be=%b data=%h required 1000140c 1111 aabbccdd", a, be, d);
        end
        checks++;
        if (st !== 4'd0 || pix_written !== 4'd1) begin
            errors++;
            $display("FAIL w32_done: state=%0d written=%0d required 0 1", st, pix_written);
        end
    endtask

    task automatic test_16bpp;
        int lat, hold; logic [31:0] a, d; logic [3:0] be, st; bit to;
        pix16 = 1'b1;
        drive_pixel(32'd1, 32'd0, 32'h0000_1234, 0, 0, lat, a, be, d, hold, st, to);
        checks++;
        if (to !== 1'b0 || a !== 32'h1000_0002 || be !== 4'b0011 || d !== 32'h1234_1234) begin
            errors++;
            $display("FAIL p16_odd: addr=%h be=%b data=%h required 10000002 0011 12341234", a, be, d);
        end
        drive_pixel(32'd0, 32'd0, 32'h0000_1234, 0, 0, lat, a, be, d, hold, st, to);
        checks++;
        if (to !== 1'b0 || a !== 32'h1000_0000 || be !== 4'b1100 || d !== 32'h1234_1234) begin
            errors++;
            $display("FAIL p16_even: addr=%h be=%b data=%h required 10000000 1100 12341234", a, be, d);
        end
        checks++;
        if (pix_written !== 4'd3) begin
            errors++;
            $display("FAIL p16_count: got %0d required 3", pix_written);
        end
        pix16 = 1'b0;
    endtask

    task automatic test_clip;
        int c1, c2, lat, hold; bit r1, r2, to; logic [31:0] a, d; logic [3:0] be, st;
        drive_drop(32'd640, 32'd5, c1, r1);
        drive_drop(32'd5, 32'd480, c2, r2);
        checks++;
        if (c1 !== 3 || c2 !== 3 || r1 !== 1'b0 || r2 !== 1'b0) begin
            errors++;
            $display("FAIL clip_drop: cycles %0d/%0d req %0d/%0d required 3/3 0/0", c1, c2, r1, r2);
        end
        checks++;
        if (pix_dropped !== 4'd2) begin
            errors++;
            $display("FAIL clip_count: got %0d required 2", pix_dropped);
        end
        drive_pixel(32'd639, 32'd479, 32'h0000_0055, 0, 0, lat, a, be, d, hold, st, to);
        checks++;
        if (to !== 1'b0 || a !== 32'h1012_BFFC || pix_written !== 4'd4) begin
            errors++;
            $display("FAIL clip_corner: addr=%h written=%0d required 1012bffc 4", a, pix_written);
        end
    endtask

    task automatic test_handshake;
        int lat, hold; logic [31:0] a, d; logic [3:0] be, st; bit to;
        drive_pixel(32'd10, 32'd1, 32'h0102_0304, 3, 2, lat, a, be, d, hold, st, to);
        checks++;
        if (to !== 1'b0 || hold !== 4) begin
            errors++;
            $display("FAIL hs_hold: req stable %0d cycles required 4", hold);
        end
        checks++;
        if (st !== 4'd5 || a !== 32'h1000_0A28) begin
            errors++;
            $display("FAIL hs_wait: state=%0d addr=%h required 5 10000a28", st, a);
        end
        checks++;
        if (state !== 4'd0 || pix_written !== 4'd5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hs_done: state=%0d written=%0d busy=%b required 0 5 0", state, pix_written, busy);
        end
    endtask

    task automatic test_enable;
        int bad;
        enable = 1'b0;
        fifo_data = {32'd1, 32'd1, 32'h1};
        fifo_empty = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (fifo_rd_en !== 1'b0 || state !== 4'd0) bad++;
        end
        fifo_empty = 1'b1;
        enable = 1'b1;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL enable_hold: %0d cycles left IDLE, required 0", bad);
        end
    endtask

    task automatic test_reset_in_req;
        int n;
        fifo_data = {32'd4, 32'd4, 32'h77};
        fifo_empty = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (fifo_rd_en) fifo_empty = 1'b1;
        end while (!IP2Bus_MstWr_Req && n < 20);
        fifo_empty = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (IP2Bus_MstWr_Req !== 1'b0 || state !== 4'd0 || busy !== 1'b0 ||
            pix_written !== '0 || pix_dropped !== '0 || IP2Bus_Mst_Addr !== '0) begin
            errors++;
            $display("FAIL reset_req: req=%b state=%0d wr=%0d dr=%0d addr=%h required all 0",
                     IP2Bus_MstWr_Req, state, pix_written, pix_dropped, IP2Bus_Mst_Addr);
        end
    endtask

    task automatic test_back_to_back;
        int n, first, last;
        fifo_data = {32'd7, 32'd3, 32'h0BAD_F00D};
        fifo_empty = 1'b0;
        n = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 300 && n < 17; cyc++) begin
            tick();
            Bus2IP_Mst_CmdAck = 1'b0;
            Bus2IP_Mst_Cmplt  = 1'b0;
            if (IP2Bus_MstWr_Req) begin
                n++;
                if (first < 0) first = cyc;
                last = cyc;
                Bus2IP_Mst_CmdAck = 1'b1;
                Bus2IP_Mst_Cmplt  = 1'b1;
                if (n == 17) fifo_empty = 1'b1;
            end
        end
        tick();
        Bus2IP_Mst_CmdAck = 1'b0;
        Bus2IP_Mst_Cmplt  = 1'b0;
        fifo_empty = 1'b1;
        tick();
        checks++;
        if (n !== 17 || (last - first) !== 80) begin
            errors++;
            $display("FAIL b2b_rate: %0d writes spanning %0d cycles required 17 spanning 80", n, last - first);
        end
        checks++;
        if (pix_written !== 4'd1 || state !== 4'd0) begin
            errors++;
            $display("FAIL b2b_wrap: written=%0d state=%0d required 1 0", pix_written, state);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; pix16 = 1'b0;
        fb_base = 32'h1000_0000; fb_stride = 32'd640;
        fb_width = 32'd640; fb_height = 32'd480;
        fifo_data = '0; fifo_empty = 1'b1;
        Bus2IP_Mst_CmdAck = 1'b0; Bus2IP_Mst_Cmplt = 1'b0;
        test_reset();
        test_32bpp();
        test_16bpp();
        test_clip();
        test_handshake();
        test_enable();
        test_reset_in_req();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
